stream_pattern_source: RTL and testbench

STREAM_PATTERN_SOURCE -- requirements
Module: stream_pattern_source

---
 rtl/stream_pattern_source_if.sv | 11 +
 rtl/stream_pattern_source.sv | 138 +++++++++++++
 tb/tb_stream_pattern_source.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_pattern_source_if.sv
// Output sample stream: source drives data/valid, sink drives ready-for-data.
interface stream_pattern_source_if #(
  parameter int WW_OUTPUT = 8
);
  logic signed [WW_OUTPUT-1:0] o_os_data;
  logic                        o_os_dv;
  logic                        i_os_rfd;

  modport master (output o_os_data, output o_os_dv, input i_os_rfd);
  modport slave  (input o_os_data, input o_os_dv, output i_os_rfd);
endinterface

// File: rtl/stream_pattern_source.sv
// Impulse/step/ramp/square sample generator; first sample valid the cycle after start, then one per cycle.
// Sample held while i_os_rfd is low; i_en low freezes everything.
module stream_pattern_source #(
  parameter int WW_OUTPUT = 8,
  parameter int WW_LEN    = 8
) (
  input  logic                        clk,
  input  logic                        i_rst_n,
  input  logic                        i_en,
  input  logic                        i_start,
  input  logic [1:0]                  i_mode,
  input  logic signed [WW_OUTPUT-1:0] i_amp,
  input  logic [WW_LEN-1:0]           i_len,
  input  logic [WW_LEN-1:0]           i_half_period,
  stream_pattern_source_if.master     os,
  output logic                        o_busy,
  output logic                        o_done
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  typedef enum logic [1:0] {M_IMPULSE, M_STEP, M_RAMP, M_SQUARE} mode_t;

  localparam logic [WW_LEN-1:0]           LEN_ONE = WW_LEN'(1);
  localparam logic signed [WW_OUTPUT-1:0] AMP_MIN = {1'b1, {(WW_OUTPUT-1){1'b0}}};
  localparam logic signed [WW_OUTPUT-1:0] AMP_MAX = {1'b0, {(WW_OUTPUT-1){1'b1}}};

  state_t                      state;
  mode_t                       mode_q;
  logic signed [WW_OUTPUT-1:0] amp_q;
  logic [WW_LEN-1:0]           len_q;
  logic [WW_LEN-1:0]           hp_q;
  logic [WW_LEN-1:0]           k_q;
  logic [WW_LEN-1:0]           cnt_q;
  logic                        phase_q;
  logic signed [WW_OUTPUT-1:0] acc_q;
  logic signed [WW_OUTPUT-1:0] data_q;
  logic                        dv_q;
  logic                        busy_q;
  logic                        done_q;

  logic signed [WW_OUTPUT-1:0] neg_amp;
  logic signed [WW_OUTPUT-1:0] acc_nxt;
  logic signed [WW_OUTPUT-1:0] data_nxt;
  logic [WW_LEN-1:0]           cnt_nxt;
  logic                        phase_nxt;
  logic                        xfer;
  logic                        last;

  // Negating the most negative amplitude would overflow, so it saturates.
  assign neg_amp = (amp_q == AMP_MIN) ? AMP_MAX : -amp_q;
  assign xfer    = dv_q && os.i_os_rfd && i_en;
  assign last    = (k_q + LEN_ONE) == len_q;

  always_comb begin
    acc_nxt   = acc_q + amp_q;
    cnt_nxt   = cnt_q + LEN_ONE;
    phase_nxt = phase_q;
    if (cnt_nxt == hp_q) begin
      cnt_nxt   = '0;
      phase_nxt = ~phase_q;
    end
    case (mode_q)
      M_IMPULSE: data_nxt = '0;
      M_STEP:    data_nxt = amp_q;
      M_RAMP:    data_nxt = acc_nxt;
      default:   data_nxt = phase_nxt ? neg_amp : amp_q;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      mode_q  <= M_IMPULSE;
      amp_q   <= '0;
      len_q   <= '0;
      hp_q    <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      acc_q   <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (i_en) begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            mode_q  <= mode_t'(i_mode);
            amp_q   <= i_amp;
            len_q   <= i_len;
            hp_q    <= (i_half_period == '0) ? LEN_ONE : i_half_period;
            k_q     <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            acc_q   <= '0;
            if (i_len != '0) begin
              state  <= ST_RUN;
              dv_q   <= 1'b1;
              busy_q <= 1'b1;
              // Every pattern starts at +amp except the ramp, which starts at 0.
              data_q <= (mode_t'(i_mode) == M_RAMP) ? '0 : i_amp;
            end else begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (xfer) begin
            if (last) begin
              state  <= ST_DONE;
              dv_q   <= 1'b0;
              busy_q <= 1'b0;
              data_q <= '0;
              done_q <= 1'b1;
            end else begin
              k_q     <= k_q + LEN_ONE;
              acc_q   <= acc_nxt;
              cnt_q   <= cnt_nxt;
              phase_q <= phase_nxt;
              data_q  <= data_nxt;
            end
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign os.o_os_data = data_q;
  assign os.o_os_dv   = dv_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
endmodule

// File: tb/tb_stream_pattern_source.sv
// Scoreboard bench: stimulus queues expected samples, a negedge monitor pops them on each transfer.
module tb_stream_pattern_source;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, en, start;
  logic [1:0]        mode;
  logic signed [7:0] amp;
  logic [7:0]        len, hp;
  logic              busy, done;

  stream_pattern_source_if #(.WW_OUTPUT(8)) os_if();

  stream_pattern_source #(.WW_OUTPUT(8), .WW_LEN(8)) dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_start      (start),
    .i_mode       (mode),
    .i_amp        (amp),
    .i_len        (len),
    .i_half_period(hp),
    .os           (os_if.master),
    .o_busy       (busy),
    .o_done       (done)
  );

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int cyc = 0;
  int run_cyc = 0;
  int xfer_cnt, done_cnt, busy_cnt, first_xfer, last_xfer, last_done;
  bit stall_prev = 1'b0;
  int stall_data = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic clear_counters();
    xfer_cnt = 0; done_cnt = 0; busy_cnt = 0;
    first_xfer = -1; last_xfer = -1; last_done = -1;
  endtask

  task automatic start_seq(input logic [1:0] m, input int a, input int l, input int h);
    @(posedge clk); #1;
    mode = m; amp = a[7:0]; len = l[7:0]; hp = h[7:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    run_cyc = cyc;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s: o_done not seen within %0d cycles", name, budget);
    end
  endtask

  // Monitor: compares every transfer against the scoreboard and checks hold/idle rules.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) begin done_cnt++; last_done = cyc; end
    if (os_if.o_os_dv) begin
      if (stall_prev) check("stall_hold", os_if.o_os_data, stall_data);
      if (os_if.i_os_rfd && en) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_xfer: got %0d, expected no transfer", os_if.o_os_data);
        end else begin
          check("sample", os_if.o_os_data, exp_q.pop_front());
        end
        if (xfer_cnt == 0) first_xfer = cyc;
        last_xfer = cyc;
        xfer_cnt++;
        stall_prev = 1'b0;
      end else begin
        stall_prev = 1'b1;
        stall_data = os_if.o_os_data;
      end
    end else begin
      stall_prev = 1'b0;
      check("idle_zero", os_if.o_os_data, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; start = 1'b0; mode = '0; amp = '0; len = '0; hp = '0;
    os_if.i_os_rfd = 1'b1;
    clear_counters();
    repeat (2) @(negedge clk);
    check("rst_dv", os_if.o_os_dv, 0);
    check("rst_data", os_if.o_os_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Impulse
    clear_counters();
    exp_q.push_back(64); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    start_seq(2'd0, 64, 4, 0);
    wait_done("imp_done", 20);
    repeat (2) @(negedge clk);
    check("imp_xfers", xfer_cnt, 4);
    check("imp_first", first_xfer, run_cyc);
    check("imp_consec", last_xfer - first_xfer, 3);
    check("imp_done_lat", last_done - last_xfer, 1);
    check("imp_done_cnt", done_cnt, 1);

    // Ramp with wrap
    clear_counters();
    exp_q.push_back(0); exp_q.push_back(100); exp_q.push_back(-56); exp_q.push_back(44);
    start_seq(2'd2, 100, 4, 0);
    wait_done("ramp_done", 20);
    repeat (2) @(negedge clk);
    check("ramp_xfers", xfer_cnt, 4);
    check("ramp_busy_cycles", busy_cnt, 4);

    // Square, saturated negation
    clear_counters();
    exp_q.push_back(-128); exp_q.push_back(-128); exp_q.push_back(127);
    exp_q.push_back(127); exp_q.push_back(-128); exp_q.push_back(-128);
    start_seq(2'd3, -128, 6, 2);
    wait_done("sq_done", 30);
    repeat (2) @(negedge clk);
    check("sq_xfers", xfer_cnt, 6);
    check("sq_done_cnt", done_cnt, 1);

    // Step with backpressure 1,0,0,1,1
    clear_counters();
    exp_q.push_back(5); exp_q.push_back(5); exp_q.push_back(5);
    start_seq(2'd1, 5, 3, 0);
    os_if.i_os_rfd = 1'b1;
    @(posedge clk); #1 os_if.i_os_rfd = 1'b0;
    @(posedge clk); #1 os_if.i_os_rfd = 1'b0;
    @(posedge clk); #1 os_if.i_os_rfd = 1'b1;
    @(posedge clk); #1 os_if.i_os_rfd = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("step_dv_after", os_if.o_os_dv, 0);
    check("step_done", done, 1);
    @(negedge clk);
    check("step_xfers", xfer_cnt, 3);

    // Zero-length start
    clear_counters();
    start_seq(2'd1, 33, 0, 0);
    @(negedge clk);
    check("len0_done", done, 1);
    check("len0_dv", os_if.o_os_dv, 0);
    @(negedge clk);
    check("len0_done_clear", done, 0);
    @(negedge clk);
    check("len0_xfers", xfer_cnt, 0);
    check("len0_done_cnt", done_cnt, 1);

    // Start ignored during RUN, then enable freeze for 3 cycles
    clear_counters();
    for (int i = 0; i < 6; i++) exp_q.push_back(3 * i);
    start_seq(2'd2, 3, 6, 0);
    start = 1'b1; mode = 2'd1; amp = 8'sd77; len = 8'd2;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("frz_data", os_if.o_os_data, 6);
      check("frz_dv", os_if.o_os_dv, 1);
      check("frz_busy", busy, 1);
      @(posedge clk); #1;
    end
    en = 1'b1;
    wait_done("frz_done", 30);
    repeat (2) @(negedge clk);
    check("frz_xfers", xfer_cnt, 6);
    check("frz_done_cnt", done_cnt, 1);

    // Asynchronous reset at k=2, then restart
    clear_counters();
    exp_q.push_back(0); exp_q.push_back(1);
    start_seq(2'd2, 1, 8, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dv", os_if.o_os_dv, 0);
    check("arst_data", os_if.o_os_data, 0);
    check("arst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_no_done", done_cnt, 0);
    check("arst_xfers", xfer_cnt, 2);
    check("arst_idle_dv", os_if.o_os_dv, 0);

    clear_counters();
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    start_seq(2'd2, 1, 3, 0);
    wait_done("rerun_done", 20);
    repeat (2) @(negedge clk);
    check("rerun_xfers", xfer_cnt, 3);
    check("rerun_first", first_xfer, run_cyc);
    check("rerun_done_cnt", done_cnt, 1);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
